// File: rtl/load_results.sv
`timescale 1ns/1ps
// load_results
// Read-back side of the displacement result buffer. A rising edge on
// save_done fetches three consecutive 32-bit words (dis_X, dis_Y, dis_Z)
// from the result BRAM and holds them on registered outputs until the host
// acknowledges them.
//
// Parameters
//   BASE_ADDR    byte address of dis_X
//   ADDR_STRIDE  byte step between result words
//   RD_LATENCY   BRAM read latency in cycles (1..7)
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   save_done    writer completion level; 0->1 starts one read-back
//   ack          host consumed results; clears load_done
//   dout         BRAM read data
//   addr/en/we   BRAM port controls (we is always 4'b0000)
//   dis_X/Y/Z    captured displacement words
//   load_done    results valid, held until ack
//   load_count   completed read-backs, wraps at 16 bits
module load_results #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] ADDR_STRIDE = 32'd4,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        save_done,
    input  logic        ack,
    input  logic [31:0] dout,
    output logic [31:0] addr,
    output logic        en,
    output logic [3:0]  we,
    output logic [31:0] dis_X,
    output logic [31:0] dis_Y,
    output logic [31:0] dis_Z,
    output logic        load_done,
    output logic [15:0] load_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    state_t      state_q, state_n;
    logic [1:0]  idx_q, idx_n;
    logic [2:0]  cnt_q, cnt_n;
    logic [31:0] addr_q, addr_n;
    logic        en_q, en_n;
    logic [31:0] x_q, x_n;
    logic [31:0] y_q, y_n;
    logic [31:0] z_q, z_n;
    logic        done_q, done_n;
    logic [15:0] count_q, count_n;
    logic        save_q;
    logic        start;

    assign start = save_done & ~save_q;

    // addr/en are registered, so they are loaded on the transition into
    // ISSUE; the BRAM therefore sees the address during the ISSUE cycle and
    // CAPTURE lands exactly RD_LATENCY cycles later (ISSUE + (L-1) WAIT).
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        addr_n  = addr_q;
        en_n    = en_q;
        x_n     = x_q;
        y_n     = y_q;
        z_n     = z_q;
        done_n  = done_q;
        count_n = count_q;

        case (state_q)
            IDLE: begin
                en_n = 1'b0;
                if (start) begin
                    state_n = ISSUE;
                    idx_n   = 2'd0;
                    addr_n  = BASE_ADDR;
                    en_n    = 1'b1;
                end
            end
            ISSUE: begin
                cnt_n   = LAT_M1;
                state_n = (RD_LATENCY == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                cnt_n = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                case (idx_q)
                    2'd0:    x_n = dout;
                    2'd1:    y_n = dout;
                    default: z_n = dout;
                endcase
                if (idx_q == 2'd2) begin
                    en_n    = 1'b0;
                    done_n  = 1'b1;
                    count_n = count_q + 16'd1;
                    state_n = DONE;
                end else begin
                    idx_n   = idx_q + 2'd1;
                    addr_n  = addr_q + ADDR_STRIDE;
                    state_n = ISSUE;
                end
            end
            DONE: begin
                // A fresh start takes priority over ack.
                if (start) begin
                    state_n = ISSUE;
                    idx_n   = 2'd0;
                    addr_n  = BASE_ADDR;
                    en_n    = 1'b1;
                    done_n  = 1'b0;
                end else if (ack) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            addr_q  <= addr_n;
            en_q    <= en_n;
            x_q     <= x_n;
            y_q     <= y_n;
            z_q     <= z_n;
            done_q  <= done_n;
            count_q <= count_n;
        end
        // Tracks save_done even in reset so a level already high is not an edge.
        save_q <= save_done;
    end

    assign addr       = addr_q;
    assign en         = en_q;
    assign we         = '0;
    assign dis_X      = x_q;
    assign dis_Y      = y_q;
    assign dis_Z      = z_q;
    assign load_done  = done_q;
    assign load_count = count_q;

endmodule

// File: tb/tb_load_results.sv
`timescale 1ns/1ps
// tb_load_results
// Scoreboard bench for load_results. Three instances: default build
// (latency 2, base 0), latency 1 and latency 4 (base 0x100). Each has a BRAM
// model with the matching read latency. Expected addresses and result words
// are queued when a read is started and compared as the DUT produces them.
module tb_load_results;

    localparam int unsigned NI = 3;
    localparam int unsigned L0 = 2;
    localparam int unsigned L1 = 1;
    localparam int unsigned L2 = 4;
    localparam logic [31:0] B0 = 32'h0;
    localparam logic [31:0] B1 = 32'h100;
    localparam int unsigned LAT [NI] = '{L0, L1, L2};
    localparam logic [31:0] BASEA [NI] = '{B0, B1, B1};

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        int unsigned lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        sd    [NI];
    logic        ack   [NI];
    logic [31:0] dout  [NI];
    logic [31:0] addr  [NI];
    logic        en    [NI];
    logic [3:0]  we    [NI];
    logic [31:0] dx    [NI];
    logic [31:0] dy    [NI];
    logic [31:0] dz    [NI];
    logic        ld    [NI];
    logic [15:0] cnt   [NI];

    logic [31:0] memd  [NI][3];
    logic [31:0] pipe  [NI][8];

    logic [31:0] aq    [NI][$];
    exp_t        eq    [NI][$];
    logic        en_p  [NI];
    logic [31:0] addr_p[NI];
    logic        ld_p  [NI];
    int unsigned st_cyc[NI];

    int unsigned cyc = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    load_results #(.BASE_ADDR(B0), .ADDR_STRIDE(32'd4), .RD_LATENCY(L0)) u0 (
        .clock(clock), .reset(reset), .save_done(sd[0]), .ack(ack[0]), .dout(dout[0]),
        .addr(addr[0]), .en(en[0]), .we(we[0]), .dis_X(dx[0]), .dis_Y(dy[0]), .dis_Z(dz[0]),
        .load_done(ld[0]), .load_count(cnt[0])
    );
    load_results #(.BASE_ADDR(B1), .ADDR_STRIDE(32'd4), .RD_LATENCY(L1)) u1 (
        .clock(clock), .reset(reset), .save_done(sd[1]), .ack(ack[1]), .dout(dout[1]),
        .addr(addr[1]), .en(en[1]), .we(we[1]), .dis_X(dx[1]), .dis_Y(dy[1]), .dis_Z(dz[1]),
        .load_done(ld[1]), .load_count(cnt[1])
    );
    load_results #(.BASE_ADDR(B1), .ADDR_STRIDE(32'd4), .RD_LATENCY(L2)) u2 (
        .clock(clock), .reset(reset), .save_done(sd[2]), .ack(ack[2]), .dout(dout[2]),
        .addr(addr[2]), .en(en[2]), .we(we[2]), .dis_X(dx[2]), .dis_Y(dy[2]), .dis_Z(dz[2]),
        .load_done(ld[2]), .load_count(cnt[2])
    );

    function automatic logic [31:0] mem_word(input int unsigned k, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASEA[k];
        if (off[1:0] == 2'b00 && off < 32'd12) return memd[k][off[3:2]];
        return 32'hBAD0_0000 | a;
    endfunction

    // BRAM model: address sampled each edge, data appears LAT cycles later.
    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            for (int s = 7; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
            pipe[k][0] <= mem_word(k, addr[k]);
        end
    end
    assign dout[0] = pipe[0][L0-1];
    assign dout[1] = pipe[1][L1-1];
    assign dout[2] = pipe[2][L2-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: new bus addresses and load_done rising edges against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            for (int k = 0; k < NI; k++) begin
                if (en[k] && (!en_p[k] || addr[k] != addr_p[k])) begin
                    if (aq[k].size() == 0) check($sformatf("addr_unexpected%0d", k), 32'(aq[k].size()), 32'd1);
                    else check($sformatf("addr%0d", k), addr[k], aq[k].pop_front());
                end
                if (ld[k] && !ld_p[k]) begin
                    if (eq[k].size() == 0) begin
                        check($sformatf("done_unexpected%0d", k), 32'(eq[k].size()), 32'd1);
                    end else begin
                        e = eq[k].pop_front();
                        check($sformatf("dis_X%0d", k), dx[k], e.x);
                        check($sformatf("dis_Y%0d", k), dy[k], e.y);
                        check($sformatf("dis_Z%0d", k), dz[k], e.z);
                        check($sformatf("latency%0d", k), 32'(cyc - st_cyc[k]), 32'(e.lat));
                    end
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            en_p[k]   = en[k];
            addr_p[k] = addr[k];
            ld_p[k]   = ld[k];
        end
    end

    // Called at a negedge with save_done low (and already registered low).
    task automatic start_read(input int unsigned k, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] z);
        exp_t e;
        memd[k][0] = x;
        memd[k][1] = y;
        memd[k][2] = z;
        aq[k].push_back(BASEA[k]);
        aq[k].push_back(BASEA[k] + 32'd4);
        aq[k].push_back(BASEA[k] + 32'd8);
        e.x = x; e.y = y; e.z = z;
        e.lat = 3 * (LAT[k] + 1) + 1;
        eq[k].push_back(e);
        st_cyc[k] = cyc;
        sd[k] = 1'b1;
    endtask

    task automatic wait_done(input int unsigned k);
        int n;
        n = 0;
        @(negedge clock);
        while (!ld[k] && n < 200) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("done_seen%0d", k), 32'(ld[k]), 32'd1);
    endtask

    initial begin
        int enh;
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            sd[k]  = 1'b1;
            ack[k] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("rst_addr", addr[0], 32'h0);
        check("rst_en", 32'(en[0]), 32'd0);
        check("rst_we", 32'(we[0]), 32'd0);
        check("rst_dis_X", dx[0], 32'h0);
        check("rst_load_done", 32'(ld[0]), 32'd0);
        check("rst_count", 32'(cnt[0]), 32'd0);
        reset = 1'b0;

        // Level high through reset must not start a read.
        enh = 0;
        repeat (5) begin
            @(negedge clock);
            if (en[0]) enh++;
        end
        check("level_at_reset_no_read", 32'(enh), 32'd0);
        for (int k = 0; k < NI; k++) sd[k] = 1'b0;
        @(negedge clock);

        // Basic read-back.
        start_read(0, 32'h11, 32'h22, 32'h33);
        wait_done(0);
        check("count_after_1", 32'(cnt[0]), 32'd1);
        check("we_const", 32'(we[0]), 32'd0);

        // save_done held high: no second read.
        enh = 0;
        repeat (50) begin
            @(negedge clock);
            if (en[0]) enh++;
        end
        check("hold_no_read", 32'(enh), 32'd0);
        check("hold_count", 32'(cnt[0]), 32'd1);
        check("hold_done", 32'(ld[0]), 32'd1);

        // Start coincides with ack in DONE.
        sd[0] = 1'b0;
        @(negedge clock);
        ack[0] = 1'b1;
        start_read(0, 32'h44, 32'h55, 32'h66);
        @(negedge clock);
        ack[0] = 1'b0;
        check("ack_start_done_low", 32'(ld[0]), 32'd0);
        check("ack_start_en", 32'(en[0]), 32'd1);
        wait_done(0);
        check("count_after_2", 32'(cnt[0]), 32'd2);

        // Plain ack returns to IDLE; a later ack is ignored.
        ack[0] = 1'b1;
        @(negedge clock);
        ack[0] = 1'b0;
        check("ack_clears", 32'(ld[0]), 32'd0);
        ack[0] = 1'b1;
        repeat (2) @(negedge clock);
        ack[0] = 1'b0;
        check("ack_idle_ignored", 32'(ld[0]), 32'd0);

        // Reset during WAIT of word 1.
        sd[0] = 1'b0;
        @(negedge clock);
        start_read(0, 32'h77, 32'h88, 32'h99);
        repeat (5) @(negedge clock);
        check("mid_dis_X", dx[0], 32'h77);
        check("mid_en", 32'(en[0]), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        aq[0].delete();
        eq[0].delete();
        check("abort_en", 32'(en[0]), 32'd0);
        check("abort_done", 32'(ld[0]), 32'd0);
        check("abort_dis_X", dx[0], 32'h0);
        check("abort_dis_Y", dy[0], 32'h0);
        check("abort_dis_Z", dz[0], 32'h0);
        check("abort_count", 32'(cnt[0]), 32'd0);
        reset = 1'b0;
        sd[0] = 1'b0;
        @(negedge clock);
        start_read(0, 32'hAA, 32'hBB, 32'hCC);
        wait_done(0);
        check("count_after_reset", 32'(cnt[0]), 32'd1);

        // Latency 1 and 4 builds at base 0x100.
        for (int k = 1; k < NI; k++) begin
            start_read(k, 32'hA100 + k, 32'hB200 + k, 32'hC300 + k);
            wait_done(k);
            check($sformatf("count_build%0d", k), 32'(cnt[k]), 32'd1);
        end

        // Counter wrap.
        ack[0] = 1'b1;
        @(negedge clock);
        ack[0] = 1'b0;
        sd[0] = 1'b0;
        force u0.count_q = 16'hFFFF;
        @(negedge clock);
        release u0.count_q;
        @(negedge clock);
        check("count_forced", 32'(cnt[0]), 32'h0000_FFFF);
        start_read(0, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
        wait_done(0);
        check("count_wrap", 32'(cnt[0]), 32'd0);
        check("wrap_done", 32'(ld[0]), 32'd1);

        repeat (3) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("sb_addr_empty%0d", k), 32'(aq[k].size()), 32'd0);
            check($sformatf("sb_data_empty%0d", k), 32'(eq[k].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
